// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
//   Receives PS/2 keyboard frames in the sys_clk domain and turns them into
//   complete key events. The raw pins are synchronised and the clock is
//   deglitched. Each 11-bit frame (start, 8 data LSB first, odd parity,
//   stop) is then sequenced through a small FSM. E0/F0 prefix bytes are
//   folded into the next code byte, and the resulting event is offered on
//   a valid/ready handshake.
//
// Parameters
//   FILT_LEN       : consecutive equal ps2_clk samples before the filtered level moves
//   TIMEOUT_CYCLES : sys_clk cycles allowed between sample strobes inside a frame
//
// Ports
//   sys_clk, rst_n        : system clock, synchronous active-low reset
//   ps2_clk, ps2_data     : raw asynchronous PS/2 pins (idle high)
//   key_code/ext/break    : event payload, stable while key_valid && !key_ready
//   key_valid, key_ready  : output handshake
//   frame_err             : 1-cycle pulse on parity, stop or timeout error
//   overrun               : 1-cycle pulse when an event is dropped (output full)
//   busy                  : frame FSM is not idle
module ps2_scan_sequencer #(
  parameter int FILT_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            filt_clk, filt_clk_d;
  logic [FC_W-1:0] filt_cnt;
  logic            sample;

  // NOTE: every clocked block uses non-blocking assignments, so all flops in
  // the design update together from pre-edge values and the chain below
  // really is two stages deep.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      filt_clk_d <= filt_clk;
      // Any sample that agrees with the current filtered level restarts the
      // run, so a pulse shorter than FILT_LEN samples never gets through.
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FC_W'(1);
      end
    end
  end

  assign sample = filt_clk_d & ~filt_clk;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            byte_ok;
  logic            err;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q + TO_W'(1);
    byte_ok   = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (sample && !dat_s2) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d   = {dat_s2, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample) begin
          par_d   = dat_s2;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          // Odd parity: data plus parity bit must carry an odd count of ones.
          if (dat_s2 && (^{shreg_q, par_q})) byte_ok = 1'b1;
          else                               err     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sample) to_cnt_d = '0;

    // A stalled frame is abandoned; the sample check keeps this exclusive
    // with the STOP-state decision above.
    if (state_q != IDLE && !sample && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      err      = 1'b1;
      state_d  = IDLE;
      to_cnt_d = '0;
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Prefix decoder and output handshake
  // ---------------------------------------------------------------------------
  logic ext_flag, brk_flag;
  logic ev_fire;

  assign ev_fire = byte_ok && (shreg_q != 8'hE0) && (shreg_q != 8'hF0);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= err;
      overrun   <= 1'b0;

      if (err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_ok) begin
        case (shreg_q)
          8'hE0:   ext_flag <= 1'b1;
          8'hF0:   brk_flag <= 1'b1;
          default: begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        endcase
      end

      // A held event that is not taken this cycle wins; the newcomer is lost.
      if (ev_fire) begin
        if (key_valid && !key_ready) begin
          overrun <= 1'b1;
        end else begin
          key_code  <= shreg_q;
          key_ext   <= ext_flag;
          key_break <= brk_flag;
          key_valid <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

- Receives PS/2 keyboard frames on the system clock domain and turns them into complete key events.
- Synchronises and deglitches `ps2_clk` and `ps2_data`, then sequences each 11-bit frame through a start/data/parity/stop state machine, checking parity, stop bit and timeout.
- Folds the E0 (extended) and F0 (break) prefix bytes into the following code byte.
- Sits between the PS/2 pins and the display/strobe logic, and delivers each event over a valid/ready handshake.

## Interface

Parameters:
- `FILT_LEN`, default 4: number of consecutive equal synchronised `ps2_clk` samples needed before the filtered clock level changes.
- `TIMEOUT_CYCLES`, default 100000: sys_clk cycles allowed between sample strobes inside a frame (1 ms at 100 MHz).

Ports:
- `sys_clk` in 1: system clock. This is the block's only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous, idles high.
- `ps2_data` in 1: raw PS/2 data, asynchronous, idles high.
- `key_code` out 8: scancode byte of the event.
- `key_ext` out 1: event was preceded by E0.
- `key_break` out 1: event was preceded by F0 (key released).
- `key_valid` out 1: event available.
- `key_ready` in 1: consumer accepts the event.
- `frame_err` out 1: one-cycle pulse on a parity error, stop-bit error or timeout.
- `overrun` out 1: one-cycle pulse when an event is dropped because the output is full.
- `busy` out 1: high while the frame FSM is not in IDLE.

## Operation

**Input conditioning**
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser; both flops reset to 1.
- Filtered clock:
  - Resets to 1.
  - Takes the synchronised level only after `FILT_LEN` consecutive equal samples.
- A falling edge of the filtered clock produces a one-cycle `sample` strobe. The bit sampled is the synchronised data on that cycle.

**Frame FSM (states IDLE, DATA, PARITY, STOP)**
- IDLE:
  - `sample` with data=0 (start bit): go to DATA, bit count=0.
  - `sample` with data=1: ignored.
- DATA:
  - Each `sample` right-shifts the data bit into an 8-bit shift register (LSB first).
  - After the 8th bit, go to PARITY.
- PARITY:
  - Latch the parity bit and go to STOP.
  - Parity is odd: the 8 data bits plus the parity bit must hold an odd number of ones.
- STOP:
  - On `sample`, go to IDLE.
  - If stop=1 and parity is good, the byte goes to the decoder.
  - Otherwise pulse `frame_err`.
- Timeout:
  - A counter clears on every `sample` and in IDLE.
  - In any other state, reaching `TIMEOUT_CYCLES-1` pulses `frame_err` and forces IDLE.
- Every error (parity, stop, timeout) discards the byte and clears the prefix flags.

**Decoder**
- Byte E0: set `ext_flag`; no event.
- Byte F0: set `brk_flag`; no event.
- Any other byte (including E1): produce the event {`ext_flag`, `brk_flag`, byte}, then clear both flags.
- Prefixes accumulate in any order until a code byte arrives.

**Output handshake**
- An event transfers on a cycle where `key_valid` and `key_ready` are both high.
- While `key_valid=1` and `key_ready=0`, `key_code`, `key_ext` and `key_break` hold stable.
- New event while the output is full and not accepted that cycle: the new event is dropped and `overrun` pulses; the held event is unchanged.
- New event on the same cycle the held event is accepted: the new event loads and `key_valid` stays 1.

**Reset**
- Every output resets to 0: `key_code`=00, `key_ext`, `key_break`, `key_valid`, `frame_err`, `overrun` and `busy` all 0.
- FSM resets to IDLE, flags clear, counters reset to 0.
- Reset mid-frame abandons the partial frame and produces no error pulse.

## Timing

- **`sample` latency:** `sample` asserts 2+`FILT_LEN` sys_clk cycles after a clean `ps2_clk` falling edge.
- **Event latency:** `key_valid` rises on the cycle after the stop-bit `sample`.
- **Error latency:** `frame_err` pulses on the cycle after the stop-bit `sample` or the timeout terminal count.
- **Overrun latency:** `overrun` pulses on the same cycle the dropped event would have loaded.
- **`busy`:** rises the cycle after the start-bit `sample`; falls the cycle after the stop-bit `sample` or timeout.
- **Glitch rejection:** `ps2_clk` pulses shorter than `FILT_LEN` cycles produce no `sample`.
- **Back-to-back frames:** back-to-back frames at the 10 kHz PS/2 rate must be received with no gap required.

## Test plan

Common bench settings: PS/2 half-period 40 sys_clk, `FILT_LEN`=4, `TIMEOUT_CYCLES`=1000.

1. **Reset mid-frame:** drive `rst_n`=0 for 3 cycles during a frame -> all outputs 0 and `busy`=0; the next full frame 1C is received correctly.
2. **Make code:** frame 1C, `key_ready`=1 -> `key_valid` high for exactly 1 cycle with `key_code`=1C, `key_ext`=0, `key_break`=0.
3. **Prefixed codes:**
   - Frames F0 then 1C -> exactly one event: code 1C, `key_break`=1, `key_ext`=0.
   - Frames E0, F0, 75 -> one event: code 75, `key_ext`=1, `key_break`=1.
   - No `key_valid` appears after any prefix byte.
4. **Frame errors:**
   - 1C with the parity bit flipped -> `frame_err` pulse, no event.
   - Frame with stop=0 -> `frame_err` pulse, no event.
   - Frame halted after 4 data bits -> `frame_err` 1000 cycles after the last `sample`, `busy`=0.
   - F0, then a bad frame, then 1C -> event 1C with `key_break`=0 (error cleared the flag).
5. **Backpressure:**
   - `key_ready`=0, send 1C then 32 -> `key_code` holds 1C and `overrun` pulses once at the 32 event.
   - Raise `key_ready` -> 1C accepted, then `key_valid`=0.
   - Send 32 again with `key_ready` pulsed on the same cycle the event loads -> `key_valid` stays 1 and `key_code`=32.
6. **Glitch filtering:** 2-cycle low glitches on `ps2_clk` while idle and mid-frame -> no extra bits, and frame 1C is still decoded as 1C.
